// File: rtl/flash_bus_arbiter.sv
// Arbiter sharing the QSPI configuration flash between the single-bit SPI master
// and the QSPI controller: registered round-robin grants, preemption and CS guard.
module flash_bus_arbiter #(
  parameter int unsigned GUARD_CYCLES = 4,   // 1..255
  parameter int unsigned MAX_HOLD     = 0    // 0 disables preemption
) (
  input  logic       iCLK,
  input  logic       iRESETn,
  // SPI master (single bit)
  input  logic       iSPI_REQ,
  output logic       oSPI_GNT,
  input  logic       iSPI_SCK,
  input  logic       iSPI_MOSI,
  input  logic       iSPI_CS,
  output logic       oSPI_MISO,
  // QSPI controller
  input  logic       iQSPI_REQ,
  output logic       oQSPI_GNT,
  input  logic       iQSPI_DCLK,
  input  logic       iQSPI_NCS,
  input  logic [3:0] iQSPI_DATAOUT,
  input  logic [3:0] iQSPI_DATAOE,
  output logic [3:0] oQSPI_DATAIN,
  // Flash pins
  output logic       oFLASH_SCK,
  output logic       oFLASH_CS,
  output logic [3:0] oFLASH_DOUT,
  output logic [3:0] oFLASH_DOE,
  input  logic [3:0] iFLASH_DIN,
  // Status
  output logic [1:0] oOWNER,
  output logic       oPREEMPT,
  output logic       oVIOLATION
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OWN_SPI  = 2'd1,
    ST_OWN_QSPI = 2'd2,
    ST_GUARD    = 2'd3
  } state_e;

  localparam logic [7:0]  GUARD_LOAD = 8'(GUARD_CYCLES - 1);
  localparam logic        PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [15:0] HOLD_LIMIT = (MAX_HOLD == 0) ? 16'hFFFF : 16'(MAX_HOLD);

  state_e      state_q,    state_d;
  logic [7:0]  guard_q,    guard_d;
  logic [15:0] hold_q,     hold_d;
  logic        last_spi_q, last_spi_d;
  logic        cs_hi_q,    cs_hi_d;
  logic        preempt_q,  preempt_d;
  logic        viol_q,     viol_d;

  logic own_req;
  logic other_req;
  logic own_cs;

  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    own_cs    = 1'b1;
    if (state_q == ST_OWN_SPI) begin
      own_req   = iSPI_REQ;
      other_req = iQSPI_REQ;
      own_cs    = iSPI_CS;
    end else if (state_q == ST_OWN_QSPI) begin
      own_req   = iQSPI_REQ;
      other_req = iSPI_REQ;
      own_cs    = iQSPI_NCS;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    guard_d    = guard_q;
    hold_d     = hold_q;
    last_spi_d = last_spi_q;
    cs_hi_d    = 1'b0;
    preempt_d  = 1'b0;
    viol_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // On a tie the requester that did not win last time gets the bus.
        if (iSPI_REQ && (!iQSPI_REQ || !last_spi_q)) begin
          state_d    = ST_OWN_SPI;
          last_spi_d = 1'b1;
          hold_d     = '0;
        end else if (iQSPI_REQ) begin
          state_d    = ST_OWN_QSPI;
          last_spi_d = 1'b0;
          hold_d     = '0;
        end
      end

      ST_OWN_SPI, ST_OWN_QSPI: begin
        // A preempted owner is only pulled off the bus after CS has idled high twice.
        if (!own_req || (preempt_q && own_cs && cs_hi_q)) begin
          state_d = ST_GUARD;
          guard_d = GUARD_LOAD;
          viol_d  = !own_req && !own_cs;
        end else begin
          cs_hi_d = preempt_q && own_cs;
          if (other_req && (hold_q != '1)) begin
            hold_d = hold_q + 16'd1;
          end
          preempt_d = PREEMPT_EN && (hold_d >= HOLD_LIMIT);
        end
      end

      ST_GUARD: begin
        if (guard_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q - 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q    <= ST_IDLE;
      guard_q    <= '0;
      hold_q     <= '0;
      last_spi_q <= 1'b0;
      cs_hi_q    <= 1'b0;
      preempt_q  <= 1'b0;
      viol_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      guard_q    <= guard_d;
      hold_q     <= hold_d;
      last_spi_q <= last_spi_d;
      cs_hi_q    <= cs_hi_d;
      preempt_q  <= preempt_d;
      viol_q     <= viol_d;
    end
  end

  assign oSPI_GNT   = (state_q == ST_OWN_SPI);
  assign oQSPI_GNT  = (state_q == ST_OWN_QSPI);
  assign oOWNER     = {state_q == ST_OWN_QSPI, state_q == ST_OWN_SPI};
  assign oPREEMPT   = preempt_q;
  assign oVIOLATION = viol_q;

  // Pin mux is combinational so SCK and data see no added latency.
  always_comb begin
    oFLASH_CS    = 1'b1;
    oFLASH_SCK   = 1'b0;
    oFLASH_DOUT  = '0;
    oFLASH_DOE   = '0;
    oSPI_MISO    = 1'b0;
    oQSPI_DATAIN = '0;
    case (state_q)
      ST_OWN_SPI: begin
        oFLASH_CS   = iSPI_CS;
        oFLASH_SCK  = iSPI_SCK & ~iSPI_CS;
        oFLASH_DOUT = {3'b110, iSPI_MOSI};
        oFLASH_DOE  = iSPI_CS ? 4'b0000 : 4'b1101;
        oSPI_MISO   = iFLASH_DIN[1];
      end
      ST_OWN_QSPI: begin
        oFLASH_CS    = iQSPI_NCS;
        oFLASH_SCK   = iQSPI_DCLK & ~iQSPI_NCS;
        oFLASH_DOUT  = iQSPI_DATAOUT;
        oFLASH_DOE   = iQSPI_NCS ? 4'b0000 : iQSPI_DATAOE;
        oQSPI_DATAIN = iFLASH_DIN;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Self-checking bench for flash_bus_arbiter: vector table, directed corner
// sequences and random traffic against a behavioural ownership model.
module tb_flash_bus_arbiter;

  localparam int GUARD    = 4;
  localparam int MAX_HOLD = 20;
  localparam logic [20:0] RST_BUS = 21'h040000;  // only flash CS high

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_req, spi_sck, spi_mosi, spi_cs;
  logic       q_req, q_dclk, q_ncs;
  logic [3:0] q_dout, q_oe, din;
  logic       spi_gnt, q_gnt, spi_miso, flash_sck, flash_cs, preempt, viol;
  logic [3:0] q_din, flash_dout, flash_doe;
  logic [1:0] owner;

  flash_bus_arbiter #(.GUARD_CYCLES(GUARD), .MAX_HOLD(MAX_HOLD)) dut (
    .iCLK(clk), .iRESETn(rst_n),
    .iSPI_REQ(spi_req), .oSPI_GNT(spi_gnt), .iSPI_SCK(spi_sck), .iSPI_MOSI(spi_mosi),
    .iSPI_CS(spi_cs), .oSPI_MISO(spi_miso),
    .iQSPI_REQ(q_req), .oQSPI_GNT(q_gnt), .iQSPI_DCLK(q_dclk), .iQSPI_NCS(q_ncs),
    .iQSPI_DATAOUT(q_dout), .iQSPI_DATAOE(q_oe), .oQSPI_DATAIN(q_din),
    .oFLASH_SCK(flash_sck), .oFLASH_CS(flash_cs), .oFLASH_DOUT(flash_dout),
    .oFLASH_DOE(flash_doe), .iFLASH_DIN(din),
    .oOWNER(owner), .oPREEMPT(preempt), .oVIOLATION(viol)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: who owns the bus, guard cycles still to run, fairness memory.
  int m_owner, m_guard_left, m_last, m_hold, m_cs_run;
  bit m_preempt, m_viol;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] dut_bus();
    return {spi_gnt, q_gnt, flash_cs, flash_sck, flash_dout, flash_doe,
            spi_miso, q_din, owner, preempt, viol};
  endfunction

  function automatic logic [20:0] model_bus();
    logic cs, sck, miso;
    logic [3:0] dout, doe, qd;
    cs = 1'b1; sck = 1'b0; dout = '0; doe = '0; miso = 1'b0; qd = '0;
    if (m_owner == 1) begin
      cs = spi_cs; sck = spi_sck & ~spi_cs; dout = {3'b110, spi_mosi};
      doe = spi_cs ? 4'b0000 : 4'b1101; miso = din[1];
    end else if (m_owner == 2) begin
      cs = q_ncs; sck = q_dclk & ~q_ncs; dout = q_dout;
      doe = q_ncs ? 4'b0000 : q_oe; qd = din;
    end
    return {m_owner == 1, m_owner == 2, cs, sck, dout, doe, miso, qd,
            2'(m_owner), m_preempt, m_viol};
  endfunction

  task automatic model_reset();
    m_owner = 0; m_guard_left = 0; m_last = 2; m_hold = 0; m_cs_run = 0;
    m_preempt = 0; m_viol = 0;
  endtask

  task automatic model_step();
    bit req, other, cs, forced;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_viol = 0;
    if (m_owner != 0) begin
      req    = (m_owner == 1) ? spi_req : q_req;
      other  = (m_owner == 1) ? q_req : spi_req;
      cs     = (m_owner == 1) ? spi_cs : q_ncs;
      forced = m_preempt && cs && (m_cs_run >= 1);
      if (!req || forced) begin
        m_viol = !req && !cs;
        m_owner = 0; m_guard_left = GUARD; m_preempt = 0; m_cs_run = 0;
      end else begin
        m_cs_run = (m_preempt && cs) ? m_cs_run + 1 : 0;
        if (other && m_hold < 65535) m_hold++;
        m_preempt = (m_hold >= MAX_HOLD);
      end
    end else if (m_guard_left > 0) begin
      m_guard_left--;
    end else if (spi_req && (!q_req || m_last == 2)) begin
      m_owner = 1; m_last = 1; m_hold = 0; m_cs_run = 0; m_preempt = 0;
    end else if (q_req) begin
      m_owner = 2; m_last = 2; m_hold = 0; m_cs_run = 0; m_preempt = 0;
    end
  endtask

  // One clock: compare everything at the falling edge, advance model at the rising edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check(tag, dut_bus(), model_bus());
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic       spi_cs, spi_sck, spi_mosi, q_ncs, q_dclk;
    logic [3:0] q_dout, q_oe, din;
    logic       cs, sck;
    logic [3:0] dout, doe;
    logic       miso;
    logic [3:0] qdin;
  } vec_t;

  vec_t tbl[9];

  task automatic apply_row(input int i);
    spi_cs = tbl[i].spi_cs; spi_sck = tbl[i].spi_sck; spi_mosi = tbl[i].spi_mosi;
    q_ncs = tbl[i].q_ncs; q_dclk = tbl[i].q_dclk; q_dout = tbl[i].q_dout;
    q_oe = tbl[i].q_oe; din = tbl[i].din;
    #1;
    check($sformatf("table_row%0d", i),
          {flash_cs, flash_sck, flash_dout, flash_doe, spi_miso, q_din},
          {tbl[i].cs, tbl[i].sck, tbl[i].dout, tbl[i].doe, tbl[i].miso, tbl[i].qdin});
    cycle("table_cycle");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // SPI owner rows (QSPI inputs carry noise), then QSPI owner rows (SPI noise).
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 4'hD, 4'h0, 1'b1, 4'h0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 4'hD, 4'hD, 1'b0, 4'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 4'hF, 4'h2, 1'b0, 1'b1, 4'hD, 4'hD, 1'b1, 4'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 4'hD, 1'b0, 1'b1, 4'hC, 4'hD, 1'b0, 4'h0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 4'hA, 1'b0, 1'b0, 4'hC, 4'hD, 1'b1, 4'h0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 4'hF, 4'h3, 1'b1, 1'b0, 4'h5, 4'h0, 1'b0, 4'h3};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h9, 4'hF, 4'h0, 1'b0, 1'b1, 4'h9, 4'hF, 1'b0, 4'h0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'hA, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'hA};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h6, 4'h1, 4'h5, 1'b0, 1'b1, 4'h6, 4'h1, 1'b0, 4'h5};

    // Reset with noisy pins: everything parked.
    rst_n = 1'b0; spi_req = 0; q_req = 0;
    spi_sck = 1; spi_mosi = 1; spi_cs = 0; q_dclk = 1; q_ncs = 0;
    q_dout = 4'hF; q_oe = 4'hF; din = 4'hF;
    model_reset();
    #3;
    check("reset_state", dut_bus(), RST_BUS);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", dut_bus(), RST_BUS);
    rst_n = 1'b1; spi_cs = 1; q_ncs = 1;
    repeat (3) cycle("idle");

    // SPI alone: grant after one edge, pin mux table, then release and guard.
    spi_req = 1;
    cycle("spi_req");
    check("spi_gnt", spi_gnt, 1'b1);
    check("spi_owner", owner, 2'd1);
    for (int i = 0; i < 5; i++) apply_row(i);
    spi_cs = 0; q_ncs = 1; q_dclk = 0;
    for (int i = 0; i < 6; i++) begin
      spi_mosi = i[0]; spi_sck = ~spi_sck;
      cycle("spi_xfer");
    end
    spi_cs = 1;
    cycle("spi_cs_up");
    spi_req = 0; q_req = 1;
    cycle("spi_release");
    check("release_gnt_low", spi_gnt, 1'b0);
    check("release_cs_park", flash_cs, 1'b1);
    n = 0;
    while (!q_gnt && n < 20) begin
      cycle("guard");
      n++;
    end
    check("guard_to_next_gnt", n, GUARD + 1);

    // QSPI owner: pin mux table including quad read.
    for (int i = 5; i < 9; i++) apply_row(i);
    q_req = 0; q_ncs = 1;
    repeat (GUARD + 2) cycle("q_release");

    // Owner drops REQ with CS low: single violation pulse, CS parked.
    spi_req = 1; spi_cs = 1;
    cycle("viol_grant");
    spi_cs = 0;
    cycle("viol_cs_low");
    spi_req = 0;
    cycle("viol_drop");
    check("viol_pulse", viol, 1'b1);
    check("viol_cs_park", flash_cs, 1'b1);
    cycle("viol_after");
    check("viol_one_cycle", viol, 1'b0);
    spi_cs = 1;
    repeat (GUARD + 1) cycle("viol_gap");

    // Ties after reset alternate, SPI first.
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_mid_idle", dut_bus(), RST_BUS);
    cycle("reset_clk");
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      spi_req = 1; q_req = 1;
      cycle("tie_req");
      check($sformatf("tie%0d_winner", t), owner, (t % 2 == 0) ? 2'd1 : 2'd2);
      cycle("tie_hold");
      spi_req = 0; q_req = 0;
      repeat (GUARD + 1) cycle("tie_gap");
    end

    // Preemption: SPI holds with QSPI waiting.
    spi_req = 1; spi_cs = 0;
    cycle("pre_grant");
    q_req = 1;
    n = 0;
    while (!preempt && n < 40) begin
      cycle("pre_hold");
      n++;
    end
    check("preempt_at_hold", n, MAX_HOLD);
    repeat (5) cycle("pre_cs_low");
    check("pre_cs_low_keeps", {spi_gnt, preempt}, 2'b11);
    spi_cs = 1;
    cycle("pre_cs_hi1");
    check("pre_cs_hi1_keeps", spi_gnt, 1'b1);
    cycle("pre_cs_hi2");
    check("pre_forced", {spi_gnt, owner, preempt}, 4'b0000);
    n = 0;
    while (!q_gnt && n < 20) begin
      cycle("pre_guard");
      n++;
    end
    check("pre_guard_len", n, GUARD + 1);
    check("pre_qspi_owner", owner, 2'd2);
    spi_req = 0;

    // Reset mid QSPI transfer parks pins without a clock edge.
    q_ncs = 0; q_dclk = 1; q_dout = 4'hF; q_oe = 4'hF;
    cycle("q_xfer");
    check("q_xfer_cs_low", flash_cs, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", dut_bus(), RST_BUS);
    cycle("async_reset_clk");
    rst_n = 1'b1; q_ncs = 1;
    spi_req = 1; q_req = 1;
    cycle("post_reset_tie");
    check("post_reset_tie_spi", owner, 2'd1);
    spi_req = 0; q_req = 0;
    repeat (GUARD + 1) cycle("post_reset_gap");

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if (!spi_req) spi_req = ($urandom_range(0, 3) == 0);
      else if (m_owner == 1) spi_req = ($urandom_range(0, 29) != 0);
      if (!q_req) q_req = ($urandom_range(0, 3) == 0);
      else if (m_owner == 2) q_req = ($urandom_range(0, 29) != 0);
      spi_cs   = ($urandom_range(0, 2) == 0);
      q_ncs    = ($urandom_range(0, 2) == 0);
      spi_sck  = 1'($urandom);
      spi_mosi = 1'($urandom);
      q_dclk   = 1'($urandom);
      q_dout   = 4'($urandom);
      q_oe     = 4'($urandom);
      din      = 4'($urandom);
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
